i2c_master_ctrl: RTL
====================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCL quarter-period; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-006 SHALL have port cmd_addr, input, 7 bits: target slave address.
REQ-007 SHALL have port cmd_rw, input, 1 bit: transfer direction, 0 = write, 1 = read.
REQ-008 SHALL have port cmd_wdata, input, 8 bits: write byte.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 8 bits: byte read from the slave.
REQ-011 SHALL have port rsp_nack, output, 1 bit: the transaction was NACKed.
REQ-012 SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-013 SHALL have port i2c_scl, output, 1 bit: bus clock, push-pull (single master, no clock stretching).
REQ-014 SHALL have port i2c_sda, inout, 1 bit: open-drain data line; the block only drives 0 or high-Z.

Function
REQ-015 Command accept SHALL occur on a clk edge where cmd_valid=1 and cmd_ready=1.
- cmd_addr, cmd_rw and cmd_wdata SHALL be latched on that edge.
- cmd_ready SHALL be 1 only in IDLE.
REQ-016 Bit timing SHALL use 4 quarters per bit, each CLK_DIV clk cycles long.
- Q0 and Q1: SCL low; SDA changes only at Q0 start.
- Q2 and Q3: SCL high; SDA is sampled at the last clk cycle of Q2.
REQ-017 The state machine SHALL follow this sequence:
- IDLE -> START -> ADDR(7 bits, MSB first) -> RW -> ACK1 -> DATA(8 bits, MSB first) -> ACK2 -> STOP -> IDLE.
REQ-018 START SHALL hold SCL high with SDA released for Q0..Q1, then drive SDA low for Q2..Q3 while SCL stays high.
REQ-019 STOP SHALL drive SDA low with SCL low in Q0, raise SCL in Q1, then release SDA in Q2 while SCL is high.
REQ-020 In ACK1 the block SHALL release SDA and sample it.
- On 1 (NACK): set rsp_nack and go from ACK1 directly to STOP, skipping DATA and ACK2.
REQ-021 Write transfer:
- DATA drives the latched wdata bits.
- ACK2 releases SDA and samples it; a sampled 1 sets rsp_nack.
REQ-022 Read transfer:
- DATA releases SDA and shifts the sampled bits into rsp_rdata, MSB first.
- ACK2 releases SDA, i.e. the master NACKs to end a single-byte read.
REQ-023 A sampled high-Z or 1 on SDA SHALL be treated as logic 1.
REQ-024 Full transaction latency SHALL be 80*CLK_DIV clk cycles from accept to rsp_valid (20 bit-times).
- Address-NACK transaction latency SHALL be 44*CLK_DIV clk cycles (11 bit-times).
REQ-025 rsp_valid SHALL pulse for exactly one cycle on the STOP -> IDLE transition.
- rsp_nack and rsp_rdata SHALL hold their values until the next accept.
- Both SHALL clear on accept.
REQ-026 busy SHALL be 1 from the accept edge until the rsp_valid cycle, inclusive.
REQ-027 cmd_valid SHALL be ignored while busy; commands are not queued.
REQ-028 With cmd_valid held high, the next command SHALL be accepted on the cycle after rsp_valid.
- The bus SHALL therefore see STOP followed immediately by START.
REQ-029 Counter widths:
- Divider counter: 8 bits, wraps at CLK_DIV-1.
- Quarter counter: 2 bits.
- Bit counter: 3 bits, counting down with terminal count 0.

Reset
REQ-030 Reset SHALL take effect asynchronously on rst_n low, at any time including mid-transaction.
- State = IDLE, i2c_scl = 1, i2c_sda = high-Z.
- cmd_ready = 0, busy = 0, rsp_valid = 0, rsp_nack = 0, rsp_rdata = 0x00.
- All counters = 0.
REQ-031 Reset SHALL NOT generate a STOP condition.
REQ-032 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-033 The bench SHALL cover these directed scenarios (pull-up on SDA, responder model at address 0x08):
- Write addr 0x08, wdata 0xA5, slave ACKs both phases -> SDA bit sequence 0001000,0,ACK,10100101,ACK; rsp_valid at 80*CLK_DIV cycles; rsp_nack = 0.
- Read addr 0x08, slave drives 0x3C -> rsp_rdata = 0x3C; rsp_nack = 0; SDA released during ACK2.
- Write addr 0x09, no slave responds -> rsp_nack = 1; rsp_valid at 44*CLK_DIV cycles; no DATA clocks on SCL.
- Write addr 0x08, slave NACKs the data byte -> rsp_nack = 1; STOP issued; next command accepted normally.
- rst_n asserted at DATA bit 3 -> SCL = 1 and SDA = Z immediately; busy = 0; rsp_valid never pulses; the next command completes correctly.
- Two back-to-back commands with CLK_DIV = 1 and cmd_valid held high -> second accept on the cycle after rsp_valid; STOP then START observed on the bus.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ctrl
// Purpose  : Single-byte I2C master: START, 7-bit address + R/W, one data byte,
//            STOP. Four SCL quarters per bit, each CLK_DIV clk cycles long.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       i2c_scl,
    inout  wire        i2c_sda
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_RW    = 3'd3;
    localparam logic [2:0] c_ST_ACK1  = 3'd4;
    localparam logic [2:0] c_ST_DATA  = 3'd5;
    localparam logic [2:0] c_ST_ACK2  = 3'd6;
    localparam logic [2:0] c_ST_STOP  = 3'd7;

    logic [2:0] state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rdy_q;

    logic w_idle, w_accept, w_qend, w_sample, w_bitend, w_sda_in;
    logic w_scl, w_sda_low;

    assign w_idle   = (state_q == c_ST_IDLE);
    assign w_qend   = (div_q == c_DIV_LAST);
    assign w_sample = w_qend && (qtr_q == 2'd2);
    assign w_bitend = w_qend && (qtr_q == 2'd3);
    assign w_sda_in = i2c_sda;

    // The response cycle itself is not ready, so a held cmd_valid is taken one cycle later
    assign cmd_ready = rdy_q && w_idle && !rsp_valid_q;
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = !w_idle || rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        rsp_valid_d = 1'b0;
        if (w_idle) begin
            div_d = 8'd0;
            qtr_d = 2'd0;
            if (w_accept) begin
                state_d = c_ST_START;
                addr_d  = cmd_addr;
                rw_d    = cmd_rw;
                wdata_d = cmd_wdata;
                rdata_d = 8'h00;
                nack_d  = 1'b0;
            end
        end else begin
            div_d = w_qend ? 8'd0 : div_q + 8'd1;
            if (w_qend) begin
                qtr_d = qtr_q + 2'd1;
            end
            if (w_sample) begin
                case (state_q)
                    c_ST_ACK1: nack_d = w_sda_in;
                    c_ST_DATA: if (rw_q) rdata_d = {rdata_q[6:0], w_sda_in};
                    c_ST_ACK2: if (!rw_q && w_sda_in) nack_d = 1'b1;
                    default: ;
                endcase
            end
            if (w_bitend) begin
                case (state_q)
                    c_ST_START: begin
                        state_d = c_ST_ADDR;
                        bit_d   = 3'd6;
                    end
                    c_ST_ADDR: begin
                        if (bit_q == 3'd0) state_d = c_ST_RW;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    c_ST_RW:   state_d = c_ST_ACK1;
                    c_ST_ACK1: begin
                        state_d = nack_q ? c_ST_STOP : c_ST_DATA;
                        bit_d   = 3'd7;
                    end
                    c_ST_DATA: begin
                        if (bit_q == 3'd0) state_d = c_ST_ACK2;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    c_ST_ACK2: state_d = c_ST_STOP;
                    default: begin
                        state_d     = c_ST_IDLE;
                        bit_d       = 3'd0;
                        rsp_valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Bus pins decode straight from state registers so reset releases them at once
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (state_q)
            c_ST_START: w_sda_low = qtr_q[1];
            c_ST_ADDR: begin
                w_scl     = qtr_q[1];
                w_sda_low = ~addr_q[bit_q];
            end
            c_ST_RW: begin
                w_scl     = qtr_q[1];
                w_sda_low = ~rw_q;
            end
            c_ST_ACK1, c_ST_ACK2: w_scl = qtr_q[1];
            c_ST_DATA: begin
                w_scl     = qtr_q[1];
                w_sda_low = ~rw_q & ~wdata_q[bit_q];
            end
            c_ST_STOP: begin
                w_scl     = (qtr_q != 2'd0);
                w_sda_low = ~qtr_q[1];
            end
            default: ;
        endcase
    end

    assign i2c_scl = w_scl;
    assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            div_q       <= 8'd0;
            qtr_q       <= 2'd0;
            bit_q       <= 3'd0;
            addr_q      <= 7'd0;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            rsp_valid_q <= rsp_valid_d;
            rdy_q       <= 1'b1;
        end
    end

endmodule
`default_nettype wire
